// File: rtl/bus_pkg.sv
// Shared bus constants and bus_if state encoding.
package bus_pkg;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        ACCESS = 3'd2,
        WAIT   = 3'd3,
        HOLD   = 3'd4
    } bus_if_state_e;

endpackage

// File: rtl/bus_if_timer.sv
// Saturating ready-timeout counter for bus_if.
module bus_if_timer #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_timeout = (r_cnt == LAST);

endmodule

// File: rtl/bus_if.sv
// Bus master interface: sequences one pipeline access onto the shared bus,
// with ready-timeout abort and a hold state for stalled pipelines.
module bus_if
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   busy,
    output logic                   bus_err,
    output logic                   bus_req_,
    input  logic                   bus_grnt_,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy_
);

    bus_if_state_e r_state;
    bus_if_state_e w_next;

    logic [WORD_ADDR_W-1:0] r_addr;
    logic                   r_rw;
    logic [WORD_DATA_W-1:0] r_wdata;
    logic [WORD_DATA_W-1:0] r_rd_buf;
    logic                   r_err_buf;

    logic w_latch;
    logic w_grant;
    logic w_abort;
    logic w_done;
    logic w_tmo;
    logic w_cnt_en;
    logic w_timeout;

    bus_if_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_grant),
        .i_en      (w_cnt_en),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_grant  = 1'b0;
        w_abort  = 1'b0;
        w_done   = 1'b0;
        w_tmo    = 1'b0;
        w_cnt_en = 1'b0;
        busy     = 1'b0;
        rd_data  = r_rd_buf;
        bus_err  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!as_ && !flush) begin
                    busy    = 1'b1;
                    w_latch = 1'b1;
                    w_next  = REQ;
                end
            end
            REQ: begin
                busy = 1'b1;
                if (flush) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end else if (!bus_grnt_) begin
                    w_grant = 1'b1;
                    w_next  = ACCESS;
                end
            end
            ACCESS, WAIT: begin
                // Flush is deliberately ignored: the slave already saw the strobe.
                w_cnt_en = 1'b1;
                w_tmo    = (r_state == WAIT) && bus_rdy_ && w_timeout;
                w_done   = !bus_rdy_ || w_tmo;
                rd_data  = bus_rdy_ ? '0 : bus_rd_data;
                bus_err  = w_tmo;
                busy     = !w_done;
                if (w_done) begin
                    w_next = stall ? HOLD : IDLE;
                end else begin
                    w_next = WAIT;
                end
            end
            HOLD: begin
                bus_err = r_err_buf;
                if (!stall) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (reset) begin
            busy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_addr    <= '0;
            bus_rw      <= READ;
            bus_wr_data <= '0;
            r_addr      <= '0;
            r_rw        <= READ;
            r_wdata     <= '0;
            r_rd_buf    <= '0;
            r_err_buf   <= 1'b0;
        end else begin
            bus_as_ <= DISABLE_;
            if (w_latch) begin
                r_addr   <= addr;
                r_rw     <= rw;
                r_wdata  <= wr_data;
                bus_req_ <= ENABLE_;
            end
            if (w_abort) begin
                bus_req_ <= DISABLE_;
            end
            if (w_grant) begin
                bus_as_     <= ENABLE_;
                bus_addr    <= r_addr;
                bus_rw      <= r_rw;
                bus_wr_data <= r_wdata;
            end
            if (w_done) begin
                bus_req_  <= DISABLE_;
                r_err_buf <= bus_err;
                if (r_rw == READ) begin
                    r_rd_buf <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_if.sv
// Randomized transaction-level check of bus_if against a timeline model.
module tb_bus_if;
    import bus_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [29:0] addr;
    logic        as_;
    logic        rw;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        busy;
    logic        bus_err;
    logic        bus_req_;
    logic        bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_rdbuf;
    logic        m_errbuf;
    logic [29:0] m_addr;
    logic        m_rw;
    logic [31:0] m_wdata;

    bus_if #(
        .TIMEOUT (TMO),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .addr        (addr),
        .as_         (as_),
        .rw          (rw),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .busy        (busy),
        .bus_err     (bus_err),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset       = 1'b0;
        as_         = 1'b1;
        flush       = 1'b0;
        stall       = 1'b0;
        bus_grnt_   = 1'b1;
        bus_rdy_    = 1'b1;
        rw          = 1'($urandom);
        addr        = 30'($urandom);
        wr_data     = $urandom;
        bus_rd_data = $urandom;
    endtask

    task automatic model_reset();
        m_rdbuf  = '0;
        m_errbuf = 1'b0;
        m_addr   = '0;
        m_rw     = READ;
        m_wdata  = '0;
    endtask

    task automatic chk_bus_idle(input string t);
        chk({t, "_req"}, 32'(bus_req_), 32'(DISABLE_));
        chk({t, "_as"}, 32'(bus_as_), 32'(DISABLE_));
        chk({t, "_addr"}, 32'(bus_addr), 32'(m_addr));
        chk({t, "_rw"}, 32'(bus_rw), 32'(m_rw));
        chk({t, "_wd"}, bus_wr_data, m_wdata);
    endtask

    // One access: grant after gdly REQ cycles, ready after nwait wait
    // states (or timeout), then nstall HOLD cycles. fl_at>=0 flushes in REQ.
    task automatic do_access(input logic a_rw, input logic [29:0] a_addr,
                             input logic [31:0] a_wd, input logic [31:0] a_rd,
                             input int gdly, input int nwait, input int nstall,
                             input int fl_at, input bit hold_as);
        bit rdy_hit;
        bit to;
        bit done;
        idle_inputs();
        as_     = 1'b0;
        rw      = a_rw;
        addr    = a_addr;
        wr_data = a_wd;
        sample();
        chk("idle_busy", 32'(busy), 32'd1);
        chk("idle_rd", rd_data, m_rdbuf);
        chk("idle_err", 32'(bus_err), 32'd0);
        chk_bus_idle("idle");
        next_cyc();
        for (int g = 0; g <= gdly; g++) begin
            idle_inputs();
            as_       = hold_as ? 1'b0 : 1'b1;
            bus_grnt_ = (g == gdly) ? 1'b0 : 1'b1;
            flush     = (g == fl_at);
            sample();
            chk("req_busy", 32'(busy), 32'd1);
            chk("req_req", 32'(bus_req_), 32'(ENABLE_));
            chk("req_as", 32'(bus_as_), 32'(DISABLE_));
            chk("req_addr", 32'(bus_addr), 32'(m_addr));
            next_cyc();
            if (g == fl_at) begin
                idle_inputs();
                sample();
                chk("flush_busy", 32'(busy), 32'd0);
                chk_bus_idle("flush");
                next_cyc();
                return;
            end
        end
        m_addr  = a_addr;
        m_rw    = a_rw;
        m_wdata = a_wd;
        for (int w = 0; w < 64; w++) begin
            idle_inputs();
            as_         = hold_as ? 1'b0 : 1'b1;
            bus_grnt_   = 1'b0;
            flush       = 1'($urandom);
            rdy_hit     = (w == nwait);
            to          = !rdy_hit && (w == TMO - 1);
            done        = rdy_hit || to;
            bus_rdy_    = !rdy_hit;
            bus_rd_data = rdy_hit ? a_rd : $urandom;
            stall       = done ? (nstall > 0) : 1'($urandom);
            sample();
            chk("acc_req", 32'(bus_req_), 32'(ENABLE_));
            chk("acc_as", 32'(bus_as_), (w == 0) ? 32'd0 : 32'd1);
            chk("acc_addr", 32'(bus_addr), 32'(m_addr));
            chk("acc_rw", 32'(bus_rw), 32'(m_rw));
            chk("acc_wd", bus_wr_data, m_wdata);
            chk("acc_busy", 32'(busy), 32'(!done));
            if (done) begin
                chk("done_rd", rd_data, to ? 32'd0 : a_rd);
                chk("done_err", 32'(bus_err), 32'(to));
                m_errbuf = to;
                if (a_rw == READ) begin
                    m_rdbuf = to ? 32'd0 : a_rd;
                end
            end
            next_cyc();
            if (done) begin
                break;
            end
            if (w == 63) begin
                chk("acc_bound", 32'd0, 32'd1);
            end
        end
        for (int h = 0; h < nstall; h++) begin
            idle_inputs();
            as_   = 1'b0;
            stall = (h < nstall - 1);
            sample();
            chk("hold_busy", 32'(busy), 32'd0);
            chk("hold_rd", rd_data, m_rdbuf);
            chk("hold_err", 32'(bus_err), 32'(m_errbuf));
            chk_bus_idle("hold");
            next_cyc();
        end
    endtask

    task automatic idle_flush();
        idle_inputs();
        as_   = 1'b0;
        flush = 1'b1;
        sample();
        chk("iflush_busy", 32'(busy), 32'd0);
        next_cyc();
        idle_inputs();
        sample();
        chk("iflush_busy2", 32'(busy), 32'd0);
        chk_bus_idle("iflush");
        next_cyc();
    endtask

    task automatic reset_in_wait();
        idle_inputs();
        as_ = 1'b0;
        sample();
        chk("rw_busy0", 32'(busy), 32'd1);
        next_cyc();
        idle_inputs();
        bus_grnt_ = 1'b0;
        next_cyc();
        idle_inputs();
        bus_grnt_ = 1'b0;
        sample();
        chk("rw_acc_busy", 32'(busy), 32'd1);
        next_cyc();
        idle_inputs();
        bus_grnt_ = 1'b0;
        reset     = 1'b1;
        sample();
        chk("rw_rst_busy", 32'(busy), 32'd0);
        next_cyc();
        model_reset();
        idle_inputs();
        sample();
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_rd", rd_data, 32'd0);
        chk_bus_idle("rw");
        next_cyc();
    endtask

    initial begin
        int k;
        int gd;
        idle_inputs();
        reset = 1'b1;
        as_   = 1'b0;
        model_reset();
        next_cyc();
        sample();
        chk("rst_busy", 32'(busy), 32'd0);
        next_cyc();
        idle_inputs();
        sample();
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk_bus_idle("rst");
        next_cyc();

        do_access(READ, 30'h10, $urandom, 32'hDEADBEEF, 0, 0, 0, -1, 1'b0);
        do_access(WRITE, 30'($urandom), 32'h12345678, $urandom, 3, 2, 0, -1, 1'b0);
        do_access(READ, 30'($urandom), $urandom, $urandom, 0, 9, 0, -1, 1'b0);
        do_access(READ, 30'($urandom), $urandom, 32'hCAFEF00D, 1, 1, 3, -1, 1'b1);
        do_access(READ, 30'($urandom), $urandom, $urandom, 0, 3, 0, -1, 1'b0);
        do_access(READ, 30'($urandom), $urandom, $urandom, 2, 0, 0, 2, 1'b0);
        idle_flush();
        reset_in_wait();
        do_access(READ, 30'($urandom), $urandom, 32'h0BADF00D, 0, 1, 1, -1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            k  = $urandom_range(0, 19);
            gd = $urandom_range(0, 3);
            if (k < 2) begin
                idle_flush();
            end else if (k < 3) begin
                reset_in_wait();
            end else begin
                do_access(1'($urandom), 30'($urandom), $urandom, $urandom,
                          gd, $urandom_range(0, 5), $urandom_range(0, 2),
                          (k < 6) ? $urandom_range(0, gd) : -1,
                          1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
